// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Puts the CPU's separate instruction and data ports onto one shared,
//   variable-latency memory bus. While cpu_stall is high the arbiter first
//   performs the pending data access (if any) and then the instruction fetch.
//   It then releases the pipeline for exactly one clock, with cpu_iin and
//   cpu_din valid during that clock.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When the macro is defined, each access gives up after TIMEOUT cycles
//   without an ack. A read that gives up returns ERR_DATA, and a write that
//   gives up is dropped. The sticky bus_err flag is then set.
//   When the macro is undefined, the arbiter waits for ack indefinitely and
//   bus_err is tied low.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   cpu_iaddr                instruction fetch address
//   cpu_daddr / cpu_dout     data address / store data
//   cpu_drw                  [1]=read, [0]=write, 00=none, 11=write
//   cpu_iin / cpu_din        registered fetched instruction / load data
//   cpu_stall                freezes the CPU pipeline
//   mem_req/mem_rd/mem_wr    bus request and strobes
//   mem_addr / mem_wdata     bus address / write data
//   mem_rdata / mem_ack      bus read data / transfer complete
//   bus_err                  sticky timeout flag
module cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_iaddr,
    input  logic [31:0] cpu_daddr,
    input  logic [31:0] cpu_dout,
    input  logic [1:0]  cpu_drw,
    output logic [31:0] cpu_iin,
    output logic [31:0] cpu_din,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] iin_q, iin_d;
    logic [31:0] din_q, din_d;
    logic        busy;       // a bus access is in flight this cycle
    logic        expire;     // access gives up this cycle without an ack
    logic        done;       // access completes this cycle (ack or expiry)
    logic [31:0] rdata_eff;  // ack wins over expiry in the same cycle
    logic        dacc;

    assign dacc      = (cpu_drw != 2'b00);
    assign busy      = (state_q == DATA) || (state_q == FETCH);
    assign done      = busy && (mem_ack || expire);
    assign rdata_eff = mem_ack ? mem_rdata : ERR_DATA;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    always_comb begin
        expire = busy && !mem_ack && (cnt_q == 16'(TIMEOUT - 1));
        // The counter restarts on every new access, including the
        // back-to-back DATA->FETCH hand-over.
        cnt_d  = 16'd0;
        if (busy && !done) begin
            cnt_d = cnt_q + 16'd1;
        end
        err_d  = err_q | expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT[15:0], ERR_DATA};
    assign expire        = 1'b0;
    assign bus_err       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        iin_d     = iin_q;
        din_d     = din_q;
        cpu_stall = 1'b1;
        mem_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                state_d = dacc ? DATA : FETCH;
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_addr  = cpu_daddr;
                mem_wr    = cpu_drw[0];
                mem_rd    = cpu_drw[1] & ~cpu_drw[0];
                mem_wdata = cpu_dout;
                if (done) begin
                    if (cpu_drw == 2'b10) begin
                        din_d = rdata_eff;
                    end
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = cpu_iaddr;
                if (done) begin
                    iin_d   = rdata_eff;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The pipeline advances on this edge. cpu_drw already
                // describes the instruction that comes next.
                cpu_stall = 1'b0;
                state_d   = dacc ? DATA : FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            iin_q   <= 32'd0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            iin_q   <= iin_d;
            din_q   <= din_d;
        end
    end

    assign cpu_iin = iin_q;
    assign cpu_din = din_q;

endmodule
